lsq_issue_queue: RTL and testbench

In-order load/store issue queue that sits directly upstream of the L1 data cache. It buffers memory micro-ops from the execute/address-generation stage and drives the cache request port one operation at a time. It samples the cache's registered `lw_data`/`cacheMiss` response, retries load misses with a fixed back-off, and reports completions to the ROB/writeback side.

---
 rtl/lsq_issue_queue.sv | 173 +++++++++++++++++
 tb/tb_lsq_issue_queue.sv | 359 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsq_issue_queue.sv
// In-order load/store issue queue feeding the L1 data cache request port.
// One op in flight at a time; load misses are retried after a fixed back-off.
module lsq_issue_queue #(
  parameter int DEPTH     = 8,
  parameter int TAG_W     = 6,
  parameter int MISS_WAIT = 4,
  parameter int MAX_RETRY = 3
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             flush,
  input  logic             enq_valid,
  output logic             enq_ready,
  input  logic             enq_is_store,
  input  logic             enq_size,
  input  logic [31:0]      enq_addr,
  input  logic [31:0]      enq_data,
  input  logic [31:0]      enq_pc,
  input  logic [TAG_W-1:0] enq_tag,
  output logic [31:0]      PC_out,
  output logic [31:0]      address_out,
  output logic [31:0]      data_sw,
  output logic             memRead,
  output logic             memWrite,
  output logic             storeSize,
  output logic             fromLSQ,
  input  logic [31:0]      lw_data,
  input  logic             cacheMiss,
  output logic             ld_done_valid,
  output logic [TAG_W-1:0] ld_done_tag,
  output logic [31:0]      ld_done_data,
  output logic             ld_done_miss,
  output logic             st_done_valid,
  output logic [TAG_W-1:0] st_done_tag,
  output logic [1:0]       dbg_state
);

  // Handshake: an op transfers on a rising edge where enq_valid && enq_ready;
  // enq_ready depends only on occupancy, flush and reset, never on enq_valid.

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int RW = $clog2(MAX_RETRY + 1);
  localparam int BW = $clog2(MISS_WAIT + 1);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_REQ     = 2'd1;
  localparam logic [1:0] S_RESP    = 2'd2;
  localparam logic [1:0] S_BACKOFF = 2'd3;

  localparam logic [CW-1:0] FULL       = CW'(DEPTH);
  localparam logic [RW-1:0] RETRY_LAST = RW'(MAX_RETRY - 1);
  localparam logic [BW-1:0] WAIT_INIT  = BW'(MISS_WAIT);

  logic             q_is_store [DEPTH];
  logic             q_size     [DEPTH];
  logic [31:0]      q_addr     [DEPTH];
  logic [31:0]      q_data     [DEPTH];
  logic [31:0]      q_pc       [DEPTH];
  logic [TAG_W-1:0] q_tag      [DEPTH];

  logic [PW-1:0] head, tail;
  logic [CW-1:0] count;
  logic [1:0]    state;
  logic [RW-1:0] retry_cnt;
  logic [BW-1:0] bo_cnt;

  logic push, pop, issue;
  logic h_is_store;

  assign enq_ready  = !rstn && !flush && (count != FULL);
  assign push       = enq_valid && enq_ready;
  assign h_is_store = q_is_store[head];
  assign dbg_state  = state;

  // A load pops on a hit or on its final allowed miss; a store always pops.
  assign pop   = !flush && (state == S_RESP) &&
                 (h_is_store || !cacheMiss || (retry_cnt == RETRY_LAST));
  assign issue = !flush && (((state == S_IDLE) && (count != '0)) ||
                            ((state == S_BACKOFF) && (bo_cnt == BW'(1))));

  always_ff @(posedge clk) begin
    if (push) begin
      q_is_store[tail] <= enq_is_store;
      q_size[tail]     <= enq_size;
      q_addr[tail]     <= enq_addr;
      q_data[tail]     <= enq_data;
      q_pc[tail]       <= enq_pc;
      q_tag[tail]      <= enq_tag;
    end
  end

  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      head          <= '0;
      tail          <= '0;
      count         <= '0;
      state         <= S_IDLE;
      retry_cnt     <= '0;
      bo_cnt        <= '0;
      PC_out        <= '0;
      address_out   <= '0;
      data_sw       <= '0;
      memRead       <= 1'b0;
      memWrite      <= 1'b0;
      storeSize     <= 1'b0;
      fromLSQ       <= 1'b0;
      ld_done_valid <= 1'b0;
      ld_done_tag   <= '0;
      ld_done_data  <= '0;
      ld_done_miss  <= 1'b0;
      st_done_valid <= 1'b0;
      st_done_tag   <= '0;
    end else begin
      memRead       <= 1'b0;
      memWrite      <= 1'b0;
      ld_done_valid <= 1'b0;
      st_done_valid <= 1'b0;
      fromLSQ       <= flush;
      if (flush) begin
        head      <= '0;
        tail      <= '0;
        count     <= '0;
        state     <= S_IDLE;
        retry_cnt <= '0;
        bo_cnt    <= '0;
      end else begin
        if (push) tail <= tail + PW'(1);
        if (pop)  head <= head + PW'(1);
        count <= count + CW'(push) - CW'(pop);

        if (issue) begin
          memRead     <= !h_is_store;
          memWrite    <= h_is_store;
          address_out <= q_addr[head];
          data_sw     <= q_data[head];
          PC_out      <= q_pc[head];
          storeSize   <= q_size[head];
        end

        case (state)
          S_IDLE:  if (issue) state <= S_REQ;
          S_REQ:   state <= S_RESP;
          S_RESP: begin
            if (h_is_store) begin
              st_done_valid <= 1'b1;
              st_done_tag   <= q_tag[head];
              retry_cnt     <= '0;
              state         <= S_IDLE;
            end else if (!cacheMiss || (retry_cnt == RETRY_LAST)) begin
              ld_done_valid <= 1'b1;
              ld_done_tag   <= q_tag[head];
              ld_done_data  <= cacheMiss ? 32'd0 : lw_data;
              ld_done_miss  <= cacheMiss;
              retry_cnt     <= '0;
              state         <= S_IDLE;
            end else begin
              retry_cnt <= retry_cnt + RW'(1);
              bo_cnt    <= WAIT_INIT;
              state     <= S_BACKOFF;
            end
          end
          S_BACKOFF: begin
            if (issue) state <= S_REQ;
            else       bo_cnt <= bo_cnt - BW'(1);
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_lsq_issue_queue.sv
// Bench for lsq_issue_queue: directed timing scenarios plus a randomized run,
// with a behavioural cache model and an in-order completion scoreboard.
module tb_lsq_issue_queue;

  localparam int DEPTH     = 8;
  localparam int TAG_W     = 6;
  localparam int MISS_WAIT = 4;
  localparam int MAX_RETRY = 3;

  logic             clk = 1'b0;
  logic             rstn = 1'b1;
  logic             flush = 1'b0;
  logic             enq_valid = 1'b0;
  logic             enq_ready;
  logic             enq_is_store = 1'b0;
  logic             enq_size = 1'b0;
  logic [31:0]      enq_addr = '0;
  logic [31:0]      enq_data = '0;
  logic [31:0]      enq_pc = '0;
  logic [TAG_W-1:0] enq_tag = '0;
  logic [31:0]      PC_out, address_out, data_sw;
  logic             memRead, memWrite, storeSize, fromLSQ;
  logic [31:0]      lw_data = '0;
  logic             cacheMiss = 1'b0;
  logic             ld_done_valid, ld_done_miss, st_done_valid;
  logic [TAG_W-1:0] ld_done_tag, st_done_tag;
  logic [31:0]      ld_done_data;
  logic [1:0]       dbg_state;

  lsq_issue_queue #(.DEPTH(DEPTH), .TAG_W(TAG_W), .MISS_WAIT(MISS_WAIT), .MAX_RETRY(MAX_RETRY)) dut (
    .clk(clk), .rstn(rstn), .flush(flush),
    .enq_valid(enq_valid), .enq_ready(enq_ready), .enq_is_store(enq_is_store),
    .enq_size(enq_size), .enq_addr(enq_addr), .enq_data(enq_data), .enq_pc(enq_pc),
    .enq_tag(enq_tag), .PC_out(PC_out), .address_out(address_out), .data_sw(data_sw),
    .memRead(memRead), .memWrite(memWrite), .storeSize(storeSize), .fromLSQ(fromLSQ),
    .lw_data(lw_data), .cacheMiss(cacheMiss),
    .ld_done_valid(ld_done_valid), .ld_done_tag(ld_done_tag), .ld_done_data(ld_done_data),
    .ld_done_miss(ld_done_miss), .st_done_valid(st_done_valid), .st_done_tag(st_done_tag),
    .dbg_state(dbg_state)
  );

  typedef struct packed {
    logic             is_store;
    logic             size;
    logic [31:0]      addr;
    logic [31:0]      data;
    logic [31:0]      pc;
    logic [TAG_W-1:0] tag;
    logic             exp_miss;
    logic [31:0]      exp_data;
  } op_t;

  op_t         exp_q[$];
  int          req_cyc[$];
  int          done_cyc[$];
  int          attempts[logic [31:0]];
  int          n_tests = 0;
  int          n_fail = 0;
  int          cyc = 0;
  int          a_cnt;
  logic        flush_d = 1'b0;
  logic [31:0] next_pc = 32'h0000_1000;
  op_t         mon_op;

  // ---------------- clock / reset-independent infrastructure ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk or posedge rstn)
    if (rstn) flush_d <= 1'b0;
    else      flush_d <= flush;

  function automatic logic [31:0] hit_data(input logic [31:0] a);
    return a ^ 32'h0000_9EAF;
  endfunction

  // Cache model: the op with a given PC misses on its first addr[3:2] attempts.
  always @(posedge clk) begin
    if (fromLSQ) begin
      lw_data   <= '0;
      cacheMiss <= 1'b0;
    end else if (memRead) begin
      a_cnt = attempts.exists(PC_out) ? attempts[PC_out] + 1 : 1;
      attempts[PC_out] = a_cnt;
      if (a_cnt <= int'(address_out[3:2])) begin
        cacheMiss <= 1'b1;
        lw_data   <= $urandom;
      end else begin
        cacheMiss <= 1'b0;
        lw_data   <= hit_data(address_out);
      end
    end else if (memWrite) begin
      cacheMiss <= 1'($urandom_range(0, 1));
      lw_data   <= $urandom;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: event at cycle %0d not expected", name, cyc);
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (!rstn) begin
      check("rd_wr_exclusive", 32'(memRead && memWrite), 32'd0);
      check("done_exclusive", 32'(ld_done_valid && st_done_valid), 32'd0);
      check("fromLSQ_pulse", 32'(fromLSQ), 32'(flush_d));
      if (memRead || memWrite) begin
        req_cyc.push_back(cyc);
        if (exp_q.size() == 0) fail_now("unexpected_request");
        else begin
          mon_op = exp_q[0];
          check("req_is_store", 32'(memWrite), 32'(mon_op.is_store));
          check("req_addr", address_out, mon_op.addr);
          check("req_pc", PC_out, mon_op.pc);
          check("req_size", 32'(storeSize), 32'(mon_op.size));
          if (memWrite) check("req_data_sw", data_sw, mon_op.data);
        end
      end
      if (ld_done_valid || st_done_valid) begin
        done_cyc.push_back(cyc);
        if (exp_q.size() == 0) fail_now("unexpected_done");
        else begin
          mon_op = exp_q.pop_front();
          check("done_kind", 32'(st_done_valid), 32'(mon_op.is_store));
          if (st_done_valid) check("st_tag", 32'(st_done_tag), 32'(mon_op.tag));
          else begin
            check("ld_tag", 32'(ld_done_tag), 32'(mon_op.tag));
            check("ld_data", ld_done_data, mon_op.exp_data);
            check("ld_miss", 32'(ld_done_miss), 32'(mon_op.exp_miss));
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic st, input logic sz, input logic [31:0] a, input logic [31:0] d,
                      input logic [TAG_W-1:0] t, input int max_wait, output int acc_cyc);
    op_t o;
    int  waited;
    waited       = 0;
    acc_cyc      = -1;
    enq_valid    = 1'b1;
    enq_is_store = st;
    enq_size     = sz;
    enq_addr     = a;
    enq_data     = d;
    enq_pc       = next_pc;
    enq_tag      = t;
    o.is_store   = st;
    o.size       = sz;
    o.addr       = a;
    o.data       = d;
    o.pc         = next_pc;
    o.tag        = t;
    o.exp_miss   = !st && (int'(a[3:2]) >= MAX_RETRY);
    o.exp_data   = (st || o.exp_miss) ? 32'd0 : hit_data(a);
    forever begin
      @(negedge clk);
      if (enq_ready) begin
        exp_q.push_back(o);
        acc_cyc = cyc;
        @(posedge clk);
        #1;
        break;
      end
      @(posedge clk);
      #1;
      waited++;
      if (waited > max_wait) begin
        fail_now("enq_timeout");
        break;
      end
    end
    enq_valid = 1'b0;
    next_pc   = next_pc + 32'd4;
  endtask

  task automatic wait_drain(input int bound);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < bound) begin
      tick(1);
      n++;
    end
    if (exp_q.size() != 0) begin
      fail_now("drain_timeout");
      exp_q.delete();
    end
    tick(1);
  endtask

  task automatic wait_state(input logic [1:0] s, input int bound, input string name);
    int n;
    n = 0;
    while (dbg_state != s && n < bound) begin
      tick(1);
      n++;
    end
    if (dbg_state != s) fail_now(name);
  endtask

  task automatic do_flush();
    flush = 1'b1;
    @(negedge clk);
    check("flush_blocks_enq", 32'(enq_ready), 32'd0);
    @(posedge clk);
    #1;
    flush = 1'b0;
    exp_q.delete();
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_ctrl"}, 32'({memRead, memWrite, storeSize, fromLSQ, ld_done_valid,
                                ld_done_miss, st_done_valid, enq_ready, dbg_state}), 32'd0);
    check({name, "_addr"}, address_out, 32'd0);
    check({name, "_data_sw"}, data_sw, 32'd0);
    check({name, "_pc"}, PC_out, 32'd0);
    check({name, "_ld_data"}, ld_done_data, 32'd0);
    check({name, "_tags"}, 32'({ld_done_tag, st_done_tag}), 32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int          acc;
    int          first_acc;
    logic [31:0] a;

    tick(2);
    check_reset_outputs("reset");
    rstn = 1'b0;
    @(negedge clk);
    check("ready_after_reset", 32'(enq_ready), 32'd1);
    check("idle_after_reset", 32'(dbg_state), 32'd0);
    tick(1);

    // Single load hit: handshake in cycle 0, request in cycle 2, done in cycle 4.
    send(1'b0, 1'b0, 32'h0000_2040, 32'd0, TAG_W'(5), 5, acc);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      check($sformatf("hit_memRead_c%0d", k), 32'(memRead), 32'(k == 2));
      check($sformatf("hit_done_c%0d", k), 32'(ld_done_valid), 32'(k == 4));
      if (k == 4) check("hit_data", ld_done_data, 32'h0000_BEEF);
      @(posedge clk);
      #1;
    end
    wait_drain(20);

    // Store byte: exactly one request, no retry regardless of cacheMiss.
    req_cyc.delete();
    send(1'b1, 1'b1, 32'h0000_0100, 32'h0000_00AB, TAG_W'(9), 5, acc);
    wait_drain(20);
    tick(4);
    check("store_requests", 32'(req_cyc.size()), 32'd1);

    // Persistent load miss: MAX_RETRY requests spaced MISS_WAIT+2 apart.
    req_cyc.delete();
    send(1'b0, 1'b0, 32'h0000_300C, 32'd0, TAG_W'(12), 5, acc);
    wait_drain(80);
    check("miss_requests", 32'(req_cyc.size()), 32'(MAX_RETRY));
    if (req_cyc.size() == MAX_RETRY) begin
      check("miss_spacing_1", 32'(req_cyc[1] - req_cyc[0]), 32'(MISS_WAIT + 2));
      check("miss_spacing_2", 32'(req_cyc[2] - req_cyc[1]), 32'(MISS_WAIT + 2));
    end

    // Fill: a long-missing head keeps the queue from draining while 8 ops arrive.
    done_cyc.delete();
    send(1'b0, 1'b0, 32'h0000_600C, 32'd0, TAG_W'(1), 5, acc);
    for (int i = 2; i <= DEPTH; i++) begin
      a = $urandom;
      send(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a, $urandom, TAG_W'(i), 5, acc);
    end
    @(negedge clk);
    check("full_ready_low", 32'(enq_ready), 32'd0);
    @(posedge clk);
    #1;
    send(1'b0, 1'b1, 32'h0000_7000, 32'd0, TAG_W'(9), 100, first_acc);
    check("ready_after_full_pop", 32'(first_acc), 32'(done_cyc.size() > 0 ? done_cyc[0] : -2));
    wait_drain(300);

    // Flush with the head load in RESP and three more entries behind it.
    send(1'b0, 1'b0, 32'h0000_400C, 32'd0, TAG_W'(20), 5, acc);
    for (int i = 0; i < 3; i++)
      send(1'b0, 1'b0, $urandom & 32'hFFFF_FFF3, 32'd0, TAG_W'(21 + i), 5, acc);
    wait_state(2'd2, 40, "flush_wait_resp");
    done_cyc.delete();
    req_cyc.delete();
    do_flush();
    @(negedge clk);
    check("flush_fromLSQ", 32'(fromLSQ), 32'd1);
    check("flush_idle", 32'(dbg_state), 32'd0);
    tick(1);
    @(negedge clk);
    check("flush_fromLSQ_single", 32'(fromLSQ), 32'd0);
    tick(6);
    check("flush_no_done", 32'(done_cyc.size()), 32'd0);
    check("flush_no_request", 32'(req_cyc.size()), 32'd0);
    send(1'b0, 1'b0, 32'h0000_8010, 32'd0, TAG_W'(30), 5, acc);
    wait_drain(20);
    check("post_flush_done", 32'(done_cyc.size()), 32'd1);

    // Reset asserted mid-BACKOFF: outputs clear immediately, queue comes back empty.
    send(1'b0, 1'b0, 32'h0000_500C, 32'd0, TAG_W'(40), 5, acc);
    wait_state(2'd3, 40, "reset_wait_backoff");
    #1;
    rstn = 1'b1;
    #1;
    check_reset_outputs("async_reset");
    exp_q.delete();
    tick(2);
    rstn = 1'b0;
    req_cyc.delete();
    @(negedge clk);
    check("rerelease_ready", 32'(enq_ready), 32'd1);
    check("rerelease_idle", 32'(dbg_state), 32'd0);
    tick(6);
    check("rerelease_empty", 32'(req_cyc.size()), 32'd0);

    // Randomized traffic with occasional flushes.
    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(0, 59) == 0) do_flush();
      else if ($urandom_range(0, 3) == 0) tick(1);
      else send(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom, $urandom,
                TAG_W'($urandom), 300, acc);
    end
    wait_drain(2000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #400000;
    n_tests++;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1, "time limit");
  end

endmodule
